// File: rtl/motor_pkg.sv
// Shared types and helpers for the multi-channel motor PWM controller.
package motor_pkg;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_RUN,
    CH_DEAD
  } ch_state_t;

  // LSB position of a channel's duty slice in the packed DUTY bus.
  function automatic int unsigned duty_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One H-bridge channel: run/dead/idle FSM, dead-time counter, duty latch and
// registered bridge outputs driven from the shared PWM counter.
module motor_channel
  import motor_pkg::*;
#(
  parameter int unsigned     PWM_BITS  = 8,
  parameter int unsigned     DT_W      = 27,
  parameter logic [DT_W-1:0] DEAD_TIME = 27'd124999999
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wrap,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                dir_req,
  input  logic                en_req,
  output logic                motor_dir,
  output logic                motor_en,
  output logic                busy
);

  ch_state_t           state;
  logic [DT_W-1:0]     dead_cnt;
  logic [PWM_BITS-1:0] duty_lat;
  logic [PWM_BITS-1:0] duty_eff;
  logic                pwm_on;

  // wrap marks the first slot of a period; that slot already uses the duty
  // being latched on the same edge so the whole period sees one duty value.
  always_comb begin
    duty_eff = wrap ? duty : duty_lat;
    pwm_on   = (cnt < duty_eff);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= CH_IDLE;
      dead_cnt  <= '0;
      duty_lat  <= '0;
      motor_dir <= 1'b0;
      motor_en  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (wrap) duty_lat <= duty;
      unique case (state)
        CH_IDLE: begin
          motor_en <= 1'b0;
          if (en_req) begin
            state     <= CH_RUN;
            motor_dir <= dir_req;
            motor_en  <= pwm_on;
          end
        end
        CH_RUN: begin
          if (!en_req || (dir_req != motor_dir)) begin
            state    <= CH_DEAD;
            dead_cnt <= DEAD_TIME;
            motor_en <= 1'b0;
            busy     <= 1'b1;
          end else begin
            motor_en <= pwm_on;
          end
        end
        CH_DEAD: begin
          motor_en <= 1'b0;
          if (dead_cnt == '0) begin
            busy <= 1'b0;
            if (en_req) begin
              state     <= CH_RUN;
              motor_dir <= dir_req;
              motor_en  <= pwm_on;
            end else begin
              state <= CH_IDLE;
            end
          end else begin
            dead_cnt <= dead_cnt - DT_W'(1);
          end
        end
        default: state <= CH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/motor_pwm_controller.sv
// Multi-channel DC motor driver: one shared PWM counter feeding N_CH
// independent dead-time protected H-bridge channels.
module motor_pwm_controller
  import motor_pkg::*;
#(
  parameter int unsigned     N_CH      = 2,
  parameter int unsigned     PWM_BITS  = 8,
  parameter int unsigned     DT_W      = 27,
  parameter logic [DT_W-1:0] DEAD_TIME = 27'd124999999
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_CH-1:0]          DIR_REQ,
  input  logic [N_CH-1:0]          EN_REQ,
  input  logic [N_CH*PWM_BITS-1:0] DUTY,
  output logic [N_CH-1:0]          MOTOR_DIR,
  output logic [N_CH-1:0]          MOTOR_EN,
  output logic [N_CH-1:0]          BUSY
);

  // Period is 2^PWM_BITS-1 clocks so an all-ones duty means 100 %.
  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PWM_BITS-1:0] cnt;
  logic                wrap;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PWM_BITS'(1);
    end
  end

  always_comb wrap = (cnt == '0);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    motor_channel #(
      .PWM_BITS (PWM_BITS),
      .DT_W     (DT_W),
      .DEAD_TIME(DEAD_TIME)
    ) u_ch (
      .clk      (CLK),
      .rst      (RST),
      .wrap     (wrap),
      .cnt      (cnt),
      .duty     (DUTY[duty_lsb(i, PWM_BITS) +: PWM_BITS]),
      .dir_req  (DIR_REQ[i]),
      .en_req   (EN_REQ[i]),
      .motor_dir(MOTOR_DIR[i]),
      .motor_en (MOTOR_EN[i]),
      .busy     (BUSY[i])
    );
  end

endmodule

// File: tb/tb_motor_pwm_controller.sv
// Directed bench for motor_pwm_controller with N_CH=2, PWM_BITS=4, DEAD_TIME=9.
module tb_motor_pwm_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] DIR_REQ = '0;
  logic [1:0] EN_REQ = '0;
  logic [7:0] DUTY = '0;
  logic [1:0] MOTOR_DIR, MOTOR_EN, BUSY;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned tcnt = 0;  // expected PWM count before the next edge
  int unsigned pc = 0;    // PWM count at the most recent edge
  logic ch1_chk = 1'b0;
  logic ch1_run = 1'b0;
  logic exp_dir1 = 1'b0;

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic [1:0] dir;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] e_dir;
    logic [1:0] e_en;
    logic [1:0] e_busy;
  } vec_t;

  vec_t tbl[10];

  motor_pwm_controller #(
    .N_CH     (2),
    .PWM_BITS (4),
    .DT_W     (27),
    .DEAD_TIME(27'd9)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DIR_REQ  (DIR_REQ),
    .EN_REQ   (EN_REQ),
    .DUTY     (DUTY),
    .MOTOR_DIR(MOTOR_DIR),
    .MOTOR_EN (MOTOR_EN),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; channel 1 is checked continuously once ch1_chk is set.
  task automatic tick();
    @(posedge CLK);
    pc = tcnt;
    tcnt = (!RST || tcnt == 14) ? 0 : tcnt + 1;
    @(negedge CLK);
    if (ch1_chk) begin
      chk1("ch1_dir", MOTOR_DIR[1], exp_dir1);
      chk1("ch1_en", MOTOR_EN[1], ch1_run && (pc < 8));
      chk1("ch1_busy", BUSY[1], 1'b0);
    end
  endtask

  initial begin
    int unsigned hi;

    for (int i = 0; i < 5; i++)
      tbl[i] = '{1'b0, 2'b11, 2'b11, 4'd15, 4'd15, 2'b00, 2'b00, 2'b00};
    for (int i = 5; i < 10; i++)
      tbl[i] = '{1'b1, 2'b01, 2'b01, 4'd15, 4'd8, 2'b01, 2'b01, 2'b00};

    // Reset with all requests high, then full-duty run on channel 0.
    for (int i = 0; i < 10; i++) begin
      RST = tbl[i].rst;
      EN_REQ = tbl[i].en;
      DIR_REQ = tbl[i].dir;
      DUTY = {tbl[i].d1, tbl[i].d0};
      tick();
      chk2($sformatf("vec%0d_dir", i), MOTOR_DIR, tbl[i].e_dir);
      chk2($sformatf("vec%0d_en", i), MOTOR_EN, tbl[i].e_en);
      chk2($sformatf("vec%0d_busy", i), BUSY, tbl[i].e_busy);
    end

    // Duty 5 written mid-period: duty 15 holds until the wrap.
    DUTY[3:0] = 4'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("hold15_en", MOTOR_EN[0], 1'b1);
    end
    hi = 0;
    for (int i = 0; i < 22; i++) begin
      if (i == 7) DUTY[3:0] = 4'd10;
      tick();
      if (i < 15) begin
        chk1("pwm5_en", MOTOR_EN[0], pc < 5);
        if (MOTOR_EN[0]) hi++;
      end else begin
        chk1("pwm10_en", MOTOR_EN[0], pc < 10);
      end
    end
    chk1("pwm5_count", hi == 5, 1'b1);

    // Start channel 1 at duty 8, then reverse channel 0.
    EN_REQ[1] = 1'b1;
    DIR_REQ[1] = 1'b1;
    ch1_chk = 1'b1;
    ch1_run = 1'b1;
    exp_dir1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1("run10_en", MOTOR_EN[0], pc < 10);
    end
    DIR_REQ[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("rev_busy", BUSY[0], 1'b1);
      chk1("rev_en", MOTOR_EN[0], 1'b0);
      chk1("rev_dir", MOTOR_DIR[0], 1'b1);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      chk1("rev_exit_busy", BUSY[0], 1'b0);
      chk1("rev_exit_dir", MOTOR_DIR[0], 1'b0);
      chk1("rev_exit_en", MOTOR_EN[0], pc < 10);
    end

    // Disable, with request noise during dead time.
    EN_REQ[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) DIR_REQ[0] = i[0];
      if (i == 4) EN_REQ[0] = 1'b1;
      if (i == 5) EN_REQ[0] = 1'b0;
      tick();
      chk1("dis_busy", BUSY[0], 1'b1);
      chk1("dis_en", MOTOR_EN[0], 1'b0);
      chk1("dis_dir", MOTOR_DIR[0], 1'b0);
    end
    DIR_REQ[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("idle_busy", BUSY[0], 1'b0);
      chk1("idle_en", MOTOR_EN[0], 1'b0);
      chk1("idle_dir", MOTOR_DIR[0], 1'b0);
    end
    EN_REQ[0] = 1'b1;
    tick();
    chk1("reen_dir", MOTOR_DIR[0], 1'b1);
    chk1("reen_en", MOTOR_EN[0], pc < 10);
    chk1("reen_busy", BUSY[0], 1'b0);

    // Reverse again and reset when the dead counter reads 4.
    DIR_REQ[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1("rd_busy", BUSY[0], 1'b1);
      chk1("rd_dir", MOTOR_DIR[0], 1'b1);
    end
    RST = 1'b0;
    ch1_run = 1'b0;
    exp_dir1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk2("rst_dir", MOTOR_DIR, 2'b00);
      chk2("rst_en", MOTOR_EN, 2'b00);
      chk2("rst_busy", BUSY, 2'b00);
    end
    RST = 1'b1;
    ch1_run = 1'b1;
    exp_dir1 = 1'b1;
    tick();
    chk1("post_rst_en", MOTOR_EN[0], 1'b1);
    chk1("post_rst_dir", MOTOR_DIR[0], 1'b0);
    chk1("post_rst_busy", BUSY[0], 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk1("post_rst_run_busy", BUSY[0], 1'b0);
      chk1("post_rst_run_en", MOTOR_EN[0], pc < 10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
